lcd_window_stats: RTL

//  Downstream consumer of the LCD controller's 3x3 display-window burst.

---
 rtl/lcd_window_stats.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lcd_window_stats.sv
// 3x3 window statistics for LCD controller bursts.
// Results are queued in a small FIFO and drained over valid/ready.
module lcd_window_stats #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 2,
   parameter int THRESH     = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W+3:0] res_sum,
   output logic [DATA_W-1:0] res_min,
   output logic [DATA_W-1:0] res_max,
   output logic [3:0]        res_maxpos,
   output logic [3:0]        res_cnt,
   output logic              overflow,
   output logic              abort_err
);

   localparam int SW = DATA_W + 4;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DATA_W-1:0] TH = DATA_W'(THRESH);

   typedef struct packed {
      logic [SW-1:0]     sum;
      logic [DATA_W-1:0] mn;
      logic [DATA_W-1:0] mx;
      logic [3:0]        pos;
      logic [3:0]        cnt;
   } res_t;

   typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

   state_t        state;
   logic [3:0]    beats;
   res_t          acc;
   res_t          first;
   res_t          nxt;
   logic          gt;
   res_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          full;
   logic          wr_en;

   assign gt = pix_in > TH;

   always_comb begin
      first     = '0;
      first.sum = SW'(pix_in);
      first.mn  = pix_in;
      first.mx  = pix_in;
      first.pos = 4'd0;
      first.cnt = {3'b000, gt};
      nxt       = acc;
      nxt.sum   = acc.sum + SW'(pix_in);
      nxt.cnt   = acc.cnt + {3'b000, gt};
      if (pix_in < acc.mn)
         nxt.mn = pix_in;
      // strict compare keeps the earliest index on ties
      if (pix_in > acc.mx) begin
         nxt.mx  = pix_in;
         nxt.pos = beats;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         beats     <= 4'd0;
         acc       <= '0;
         abort_err <= 1'b0;
      end else begin
         abort_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pix_valid) begin
                  acc   <= first;
                  beats <= 4'd1;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (pix_valid) begin
                  acc <= nxt;
                  if (beats == 4'd8) begin
                     beats <= 4'd0;
                     state <= PUSH;
                  end else begin
                     beats <= beats + 4'd1;
                  end
               end else begin
                  beats     <= 4'd0;
                  abort_err <= 1'b1;
                  state     <= IDLE;
               end
            end
            PUSH: begin
               if (pix_valid) begin
                  acc   <= first;
                  beats <= 4'd1;
                  state <= COLLECT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign push      = (state == PUSH);
   assign res_valid = (count != '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = res_valid && res_ready;
   assign wr_en     = push && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= acc;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (push && full && !pop)
            overflow <= 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)
            count <= count + (AW+1)'(1);
         else if (!wr_en && pop)
            count <= count - (AW+1)'(1);
      end
   end

   assign res_sum    = mem[rd_ptr].sum;
   assign res_min    = mem[rd_ptr].mn;
   assign res_max    = mem[rd_ptr].mx;
   assign res_maxpos = mem[rd_ptr].pos;
   assign res_cnt    = mem[rd_ptr].cnt;

endmodule
